// File: rtl/fpu_pkg.sv
// fpu_pkg: op codes, the quiet-NaN result and scheduler FSM states shared by
// the FPU scheduler and its arbiter.
package fpu_pkg;

  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_MUL = 2'b01;
  localparam logic [1:0]  OP_DIV = 2'b10;
  localparam logic [1:0]  OP_BAD = 2'b11;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational find-first search starting just after ptr,
// returning a one-hot grant and its index. The caller owns the pointer.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(ptr) + k) % N;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fpu_scheduler.sv
// fpu_scheduler: shares one handshake-less multi-cycle FPU between NUM_REQ
// requesters. Define FPU_SCHED_PRIO0_EN to give requester 0 strict priority.
module fpu_scheduler
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LAT_ADD = 8,
  parameter int LAT_MUL = 10,
  parameter int LAT_DIV = 30,
  parameter int CNT_W   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [2*NUM_REQ-1:0]    req_sel,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    fpu_rst,
  output logic [1:0]              fpu_sel,
  output logic [31:0]             fpu_a,
  output logic [31:0]             fpu_b,
  input  logic [31:0]             fpu_z
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, owner;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] arb_req, arb_grant, win_grant;
  logic [IDX_W-1:0]   arb_idx, win_idx;
  logic               arb_any, win_any, win_upd_ptr;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (arb_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

`ifdef FPU_SCHED_PRIO0_EN
  // Requester 0 bypasses the round-robin and leaves the pointer untouched.
  assign arb_req = {req_valid[NUM_REQ-1:1], 1'b0};
  always_comb begin
    if (req_valid[0]) begin
      win_grant   = NUM_REQ'(1);
      win_idx     = '0;
      win_any     = 1'b1;
      win_upd_ptr = 1'b0;
    end else begin
      win_grant   = arb_grant;
      win_idx     = arb_idx;
      win_any     = arb_any;
      win_upd_ptr = 1'b1;
    end
  end
`else
  assign arb_req     = req_valid;
  assign win_grant   = arb_grant;
  assign win_idx     = arb_idx;
  assign win_any     = arb_any;
  assign win_upd_ptr = 1'b1;
`endif

  function automatic logic [CNT_W-1:0] lat_m1(input logic [1:0] op);
    case (op)
      OP_ADD:  return CNT_W'(LAT_ADD - 1);
      OP_MUL:  return CNT_W'(LAT_MUL - 1);
      OP_DIV:  return CNT_W'(LAT_DIV - 1);
      default: return CNT_W'(LAT_ADD - 1);
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (win_any) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = (fpu_sel == OP_BAD) ? ST_DONE : ST_WAIT;
      ST_WAIT:   if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are gated by rst so nothing escapes during the reset cycle.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    fpu_rst   = 1'b1;
    if (!rst) begin
      case (state)
        ST_IDLE: req_ready        = win_grant;
        ST_WAIT: fpu_rst          = 1'b0;
        ST_DONE: rsp_valid[owner] = 1'b1;
        default: ;
      endcase
    end
  end

  // fpu_sel/a/b double as the operand latch and hold between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= IDX_W'(NUM_REQ - 1);
      owner    <= '0;
      cnt      <= '0;
      fpu_sel  <= OP_ADD;
      fpu_a    <= '0;
      fpu_b    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (win_any) begin
          owner   <= win_idx;
          fpu_sel <= req_sel[{win_idx, 1'b0} +: 2];
          fpu_a   <= req_a[{win_idx, 5'd0} +: 32];
          fpu_b   <= req_b[{win_idx, 5'd0} +: 32];
          if (win_upd_ptr) ptr <= win_idx;
        end
        ST_LAUNCH: begin
          if (fpu_sel == OP_BAD) begin
            rsp_data <= QNAN;
            rsp_err  <= 1'b1;
          end else begin
            cnt <= lat_m1(fpu_sel);
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rsp_data <= fpu_z;
            rsp_err  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_scheduler.sv
// tb_fpu_scheduler: randomized and directed bench for fpu_scheduler with a
// latency-accurate FPU model and a cycle-level scheduling reference model.
module tb_fpu_scheduler;
  import fpu_pkg::*;

  localparam int N       = 4;
  localparam int LAT_ADD = 8;
  localparam int LAT_MUL = 10;
  localparam int LAT_DIV = 30;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [2*N-1:0]  req_sel;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     rsp_data, fpu_a, fpu_b, fpu_z;
  logic            rsp_err, fpu_rst;
  logic [1:0]      fpu_sel;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int fcyc        = 0;

  typedef struct { logic [1:0] sel; logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct { int cyc; int idx; } acc_t;
  typedef struct { int cyc; int idx; logic [31:0] data; logic err; } rsp_t;

  op_t  pend[N][$];
  acc_t acc_log[$];
  rsp_t rsp_log[$];
  rsp_t expq[$];
  logic acc_flag[N];
  int   m_ptr, m_busy_until, m_wait_lo, m_wait_hi, rst_low_cycles;
  op_t  m_op;

  fpu_scheduler #(.NUM_REQ(N), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL),
                  .LAT_DIV(LAT_DIV), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .fpu_rst(fpu_rst),
    .fpu_sel(fpu_sel), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_z(fpu_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FPU model: result valid LAT cycles after reset release
  function automatic int lat_of(input logic [1:0] s);
    case (s)
      2'b00:   return LAT_ADD;
      2'b01:   return LAT_MUL;
      2'b10:   return LAT_DIV;
      default: return 0;
    endcase
  endfunction

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    if (e < 1 || e > 254) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      2'b00:   return r2f(f2r(a) + f2r(b));
      2'b01:   return r2f(f2r(a) * f2r(b));
      2'b10:   return (f2r(b) == 0.0) ? QNAN : r2f(f2r(a) / f2r(b));
      default: return QNAN;
    endcase
  endfunction

  always @(posedge clk) fcyc <= fpu_rst ? 0 : fcyc + 1;
  always_comb fpu_z = (fcyc >= lat_of(fpu_sel) - 1) ? fpu_calc(fpu_sel, fpu_a, fpu_b) : 32'hDEAD_BEEF;

  function automatic int ulp_diff(input logic [31:0] x, input logic [31:0] y);
    if (x[31] != y[31]) return 1000000;
    return (x[30:0] > y[30:0]) ? int'(x[30:0] - y[30:0]) : int'(y[30:0] - x[30:0]);
  endfunction

  function automatic logic [31:0] rand_f();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(110, 144));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  // ---------------- reference scheduling model (round-robin from last grant)
  function automatic int pick(input logic [N-1:0] v);
`ifdef FPU_SCHED_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic monitor_step();
    logic [N-1:0] exp_ready, exp_rsp;
    int g, lat;
    bit in_wait;
    rsp_t e, r;
    acc_t a;
    op_t  o;
    if (rsp_valid != '0) begin
      r.cyc = cyc; r.data = rsp_data; r.err = rsp_err; r.idx = -1;
      for (int i = N - 1; i >= 0; i--) if (rsp_valid[i]) r.idx = i;
      rsp_log.push_back(r);
    end
    for (int i = 0; i < N; i++)
      if (!rst && req_ready[i] && req_valid[i]) begin
        acc_flag[i] = 1'b1;
        a.cyc = cyc; a.idx = i;
        acc_log.push_back(a);
      end
    if (!fpu_rst) rst_low_cycles++;
    if (rst) begin
      m_ptr = N - 1; m_busy_until = cyc + 1; m_wait_lo = 1; m_wait_hi = 0;
      expq.delete();
      return;
    end
    exp_ready = '0;
    if (cyc >= m_busy_until && req_valid != '0) begin
      g = pick(req_valid);
      exp_ready[g] = 1'b1;
      o.sel = req_sel[2*g +: 2]; o.a = req_a[32*g +: 32]; o.b = req_b[32*g +: 32];
      e.idx = g;
      if (o.sel == 2'b11) begin
        e.cyc = cyc + 2; e.data = QNAN; e.err = 1'b1;
        m_busy_until = cyc + 3;
      end else begin
        lat = lat_of(o.sel);
        e.cyc = cyc + lat + 2; e.data = fpu_calc(o.sel, o.a, o.b); e.err = 1'b0;
        m_busy_until = cyc + lat + 3;
        m_wait_lo = cyc + 2; m_wait_hi = cyc + lat + 1; m_op = o;
      end
      expq.push_back(e);
`ifdef FPU_SCHED_PRIO0_EN
      if (g != 0) m_ptr = g;
`else
      m_ptr = g;
`endif
    end
    vectors++;
    if (req_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL req_ready @%0d: got %b expected %b", cyc, req_ready, exp_ready);
    end
    exp_rsp = '0;
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      exp_rsp[e.idx] = 1'b1;
      vectors++;
      if (rsp_data !== e.data || rsp_err !== e.err) begin
        miscompares++;
        $display("FAIL rsp_data @%0d: got %h/%b expected %h/%b", cyc, rsp_data, rsp_err, e.data, e.err);
      end
    end
    vectors++;
    if (rsp_valid !== exp_rsp) begin
      miscompares++;
      $display("FAIL rsp_valid @%0d: got %b expected %b", cyc, rsp_valid, exp_rsp);
    end
    in_wait = (cyc >= m_wait_lo && cyc <= m_wait_hi);
    vectors++;
    if (fpu_rst !== !in_wait) begin
      miscompares++;
      $display("FAIL fpu_rst @%0d: got %b expected %b", cyc, fpu_rst, !in_wait);
    end
    if (in_wait) begin
      vectors++;
      if (fpu_sel !== m_op.sel || fpu_a !== m_op.a || fpu_b !== m_op.b) begin
        miscompares++;
        $display("FAIL fpu_ops @%0d: got %h %h %h expected %h %h %h", cyc, fpu_sel, fpu_a, fpu_b, m_op.sel, m_op.a, m_op.b);
      end
    end
  endtask

  // Requesters hold valid and operands until they see req_ready.
  task automatic drive_step();
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        if (pend[i].size() > 0) pend[i].delete(0);
      end
      if (pend[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_sel[2*i +: 2]  = pend[i][0].sel;
        req_a[32*i +: 32]  = pend[i][0].a;
        req_b[32*i +: 32]  = pend[i][0].b;
      end else begin
        req_valid[i]       = 1'b0;
        req_sel[2*i +: 2]  = 2'($urandom);
        req_a[32*i +: 32]  = $urandom;
        req_b[32*i +: 32]  = $urandom;
      end
    end
  endtask

  task automatic bfm();
    forever begin
      @(negedge clk);
      monitor_step();
      @(posedge clk);
      #1;
      drive_step();
    end
  endtask

  task automatic push_op(input int i, input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.sel = s; o.a = a; o.b = b;
    pend[i].push_back(o);
  endtask

  function automatic bit quiet();
    for (int i = 0; i < N; i++) if (pend[i].size() > 0 || acc_flag[i]) return 1'b0;
    return (expq.size() == 0) && (cyc >= m_busy_until);
  endfunction

  task automatic wait_quiet(input int budget);
    int n = 0;
    while (!quiet()) begin
      @(posedge clk);
      n++;
      if (n > budget) begin
        vectors++; miscompares++;
        $display("FAIL wait_quiet: still busy after %0d cycles, required idle", n);
        return;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_accept(input int budget);
    int n = 0;
    while (acc_log.size() == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (acc_log.size() == 0) begin
      miscompares++;
      $display("FAIL wait_accept: no accept in %0d cycles, required one", budget);
    end
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== '0 || fpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold: ready=%b fpu_rst=%b required 0/1", req_ready, fpu_rst);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, rsp_err, fpu_rst} !== {{(2*N){1'b0}}, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_strobes: ready=%b rsp=%b err=%b fpu_rst=%b", req_ready, rsp_valid, rsp_err, fpu_rst);
    end
    vectors++;
    if (rsp_data !== 32'd0 || fpu_sel !== 2'd0 || fpu_a !== 32'd0 || fpu_b !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_regs: data=%h sel=%h a=%h b=%h required zeros", rsp_data, fpu_sel, fpu_a, fpu_b);
    end
  endtask

  task automatic test_fairness();
`ifdef FPU_SCHED_PRIO0_EN
    int exp_order[6] = '{0, 0, 1, 2, 3, 1};
`else
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
`endif
    acc_log.delete(); rsp_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_op(i, OP_ADD, rand_f(), rand_f());
    wait_quiet(200);
    vectors++;
    if (acc_log.size() != 2 * N || rsp_log.size() != 2 * N) begin
      miscompares++;
      $display("FAIL fair_count: acc=%0d rsp=%0d required %0d", acc_log.size(), rsp_log.size(), 2 * N);
    end else begin
      for (int k = 0; k < 2 * N; k++) begin
        if (k < 6) begin
          vectors++;
          if (acc_log[k].idx != exp_order[k]) begin
            miscompares++;
            $display("FAIL fair_order[%0d]: got %0d required %0d", k, acc_log[k].idx, exp_order[k]);
          end
        end
        if (k > 0) begin
          vectors++;
          if (acc_log[k].cyc - acc_log[k-1].cyc != LAT_ADD + 3) begin
            miscompares++;
            $display("FAIL fair_spacing[%0d]: got %0d required %0d", k, acc_log[k].cyc - acc_log[k-1].cyc, LAT_ADD + 3);
          end
        end
        vectors++;
        if (rsp_log[k].idx != acc_log[k].idx) begin
          miscompares++;
          $display("FAIL fair_route[%0d]: got %0d required %0d", k, rsp_log[k].idx, acc_log[k].idx);
        end
      end
    end
  endtask

  task automatic test_single_ops();
    logic [1:0]  sv[3] = '{OP_ADD, OP_MUL, OP_DIV};
    logic [31:0] av[3] = '{32'h41BB_EB85, 32'h40EC_CCCD, 32'h42FA_428F};
    logic [31:0] bv[3] = '{32'hC104_51EC, 32'h414E_6666, 32'h414E_6666};
    logic [31:0] zv[3] = '{32'h4173_851F, 32'h42BE_EB85, 32'h411B_3333};
    int          dv[3] = '{10, 12, 32};
    for (int t = 0; t < 3; t++) begin
      acc_log.delete(); rsp_log.delete();
      push_op(1, sv[t], av[t], bv[t]);
      wait_quiet(100);
      vectors++;
      if (acc_log.size() != 1 || rsp_log.size() != 1) begin
        miscompares++;
        $display("FAIL op%0d_count: acc=%0d rsp=%0d required 1/1", t, acc_log.size(), rsp_log.size());
      end else begin
        vectors++;
        if (acc_log[0].idx != 1 || rsp_log[0].idx != 1) begin
          miscompares++;
          $display("FAIL op%0d_idx: acc=%0d rsp=%0d required 1", t, acc_log[0].idx, rsp_log[0].idx);
        end
        vectors++;
        if (rsp_log[0].cyc - acc_log[0].cyc != dv[t]) begin
          miscompares++;
          $display("FAIL op%0d_latency: got %0d required %0d", t, rsp_log[0].cyc - acc_log[0].cyc, dv[t]);
        end
        vectors++;
        if (ulp_diff(rsp_log[0].data, zv[t]) > 1 || rsp_log[0].err !== 1'b0) begin
          miscompares++;
          $display("FAIL op%0d_result: got %h err=%b required %h err=0", t, rsp_log[0].data, rsp_log[0].err, zv[t]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    acc_log.delete(); rsp_log.delete();
    rst_low_cycles = 0;
    push_op(2, OP_BAD, rand_f(), rand_f());
    wait_quiet(50);
    vectors++;
    if (acc_log.size() != 1 || rsp_log.size() != 1) begin
      miscompares++;
      $display("FAIL illegal_count: acc=%0d rsp=%0d required 1/1", acc_log.size(), rsp_log.size());
    end else begin
      vectors++;
      if (rsp_log[0].cyc - acc_log[0].cyc != 2 || rsp_log[0].idx != 2) begin
        miscompares++;
        $display("FAIL illegal_timing: got %0d idx %0d required 2 idx 2", rsp_log[0].cyc - acc_log[0].cyc, rsp_log[0].idx);
      end
      vectors++;
      if (rsp_log[0].data !== QNAN || rsp_log[0].err !== 1'b1) begin
        miscompares++;
        $display("FAIL illegal_result: got %h err=%b required %h err=1", rsp_log[0].data, rsp_log[0].err, QNAN);
      end
    end
    vectors++;
    if (rst_low_cycles != 0) begin
      miscompares++;
      $display("FAIL illegal_fpu_rst: low for %0d cycles required 0", rst_low_cycles);
    end
  endtask

  task automatic test_reset_mid_wait();
    acc_log.delete(); rsp_log.delete();
    push_op(1, OP_DIV, rand_f(), rand_f());
    wait_accept(20);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (fpu_rst !== 1'b1 || rsp_valid !== '0) begin
      miscompares++;
      $display("FAIL midrst_state: fpu_rst=%b rsp=%b required 1/0", fpu_rst, rsp_valid);
    end
    repeat (40) @(posedge clk);
    vectors++;
    if (rsp_log.size() != 0) begin
      miscompares++;
      $display("FAIL midrst_dropped: got %0d responses required 0", rsp_log.size());
    end
    acc_log.delete();
    push_op(2, OP_MUL, rand_f(), rand_f());
    push_op(0, OP_ADD, rand_f(), rand_f());
    wait_quiet(100);
    vectors++;
    if (acc_log.size() != 2 || rsp_log.size() != 2 || acc_log[0].idx != 0) begin
      miscompares++;
      $display("FAIL midrst_restart: acc=%0d rsp=%0d first=%0d required 2/2/0", acc_log.size(), rsp_log.size(),
               (acc_log.size() > 0) ? acc_log[0].idx : -1);
    end
  endtask

  task automatic test_withdraw();
    int bad = 0;
    acc_log.delete(); rsp_log.delete();
    push_op(1, OP_DIV, rand_f(), rand_f());
    wait_accept(20);
    repeat (3) @(posedge clk);
    #1 push_op(2, OP_ADD, rand_f(), rand_f());
    repeat (10) @(posedge clk);
    #1 pend[2].delete();
    wait_quiet(100);
    foreach (acc_log[k]) if (acc_log[k].idx == 2) bad++;
    foreach (rsp_log[k]) if (rsp_log[k].idx == 2) bad++;
    vectors++;
    if (bad != 0 || acc_log.size() != 1) begin
      miscompares++;
      $display("FAIL withdraw: req2 events=%0d accepts=%0d required 0/1", bad, acc_log.size());
    end
  endtask

  task automatic test_random();
    int i;
    logic [1:0] s;
    acc_log.delete(); rsp_log.delete();
    for (int r = 0; r < 40; r++) begin
      i = $urandom_range(0, N - 1);
      s = ($urandom_range(0, 9) == 0) ? OP_BAD : 2'($urandom_range(0, 2));
      push_op(i, s, rand_f(), rand_f());
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 30)) @(posedge clk);
    end
    wait_quiet(5000);
    vectors++;
    if (acc_log.size() != 40 || rsp_log.size() != 40) begin
      miscompares++;
      $display("FAIL random_count: acc=%0d rsp=%0d required 40/40", acc_log.size(), rsp_log.size());
    end
  endtask

  initial begin
    req_valid = '0; req_sel = '0; req_a = '0; req_b = '0;
    m_ptr = N - 1; m_busy_until = 0; m_wait_lo = 1; m_wait_hi = 0; rst_low_cycles = 0;
    for (int i = 0; i < N; i++) acc_flag[i] = 1'b0;
    fork bfm(); join_none
    test_reset();
    test_fairness();
    test_single_ops();
    test_illegal();
    test_reset_mid_wait();
    test_withdraw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
